// File: rtl/regfile_pkg.sv
// Shared types for the register writeback path: default widths, register
// address/data types and the round-robin grant flag.
package regfile_pkg;

    localparam int unsigned DefaultAddrWidth = 5;
    localparam int unsigned DefaultDataWidth = 32;

    typedef logic [DefaultAddrWidth-1:0] reg_addr_t;
    typedef logic [DefaultDataWidth-1:0] reg_data_t;

    typedef enum logic {
        GrantLoad = 1'b0,
        GrantExec = 1'b1
    } grant_e;

    function automatic grant_e grant_other(input grant_e g);
        return (g == GrantLoad) ? GrantExec : GrantLoad;
    endfunction

endpackage

// File: rtl/reg_tag_fifo.sv
// In-order FIFO of load destination tags; Depth must be a power of 2 (>= 2)
// so the pointers wrap naturally.
module reg_tag_fifo #(
    parameter int unsigned Width = 5,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [Width-1:0]           push_data,
    input  logic                       pop,
    output logic [Width-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth):0]     count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CntW'(Depth));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/register_writeback_scheduler.sv
// Single-port register file write scheduler: arbitrates execute results
// against in-order load completions and tracks registers with loads pending.
module register_writeback_scheduler
    import regfile_pkg::*;
#(
    parameter int unsigned AddressBitWidth = DefaultAddrWidth,
    parameter int unsigned DataBitWidth    = DefaultDataWidth,
    parameter int unsigned LoadDepth       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ex_valid,
    output logic                          ex_ready,
    input  logic [AddressBitWidth-1:0]    ex_rd,
    input  logic [DataBitWidth-1:0]       ex_data,
    input  logic                          ld_reserve_valid,
    output logic                          ld_reserve_ready,
    input  logic [AddressBitWidth-1:0]    ld_reserve_rd,
    input  logic                          ld_done_valid,
    output logic                          ld_done_ready,
    input  logic [DataBitWidth-1:0]       ld_done_data,
    input  logic [AddressBitWidth-1:0]    query_rs1,
    input  logic [AddressBitWidth-1:0]    query_rs2,
    input  logic [AddressBitWidth-1:0]    query_rd,
    output logic                          hazard,
    output logic [AddressBitWidth-1:0]    rf_rd,
    output logic                          rf_write_enable,
    output logic [DataBitWidth-1:0]       rf_data,
    output logic [$clog2(LoadDepth):0]    pending_count
);

    localparam int unsigned NumRegs = 1 << AddressBitWidth;

    logic [NumRegs-1:0]         r_busy;
    logic [NumRegs-1:0]         w_busy_next;
    grant_e                     r_rr;
    grant_e                     w_rr_next;
    logic [AddressBitWidth-1:0] r_rf_rd;
    logic [DataBitWidth-1:0]    r_rf_data;
    logic                       r_rf_we;
    logic                       r_rf_from_ld;

    logic [AddressBitWidth-1:0] w_head;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic                       w_res_fire;
    logic                       w_done_fire;
    logic                       w_ex_fire;
    logic                       w_ex_ok;
    logic                       w_ex_elig;
    logic                       w_ld_elig;
    logic                       w_contend;
    logic                       w_haz_busy;
    logic                       w_haz_inflight;

    reg_tag_fifo #(
        .Width (AddressBitWidth),
        .Depth (LoadDepth)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_res_fire),
        .push_data (ld_reserve_rd),
        .pop       (w_done_fire),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (pending_count)
    );

    // Readies look only at state and the other requester's valid.
    assign ld_reserve_ready = !w_fifo_full && !r_busy[ld_reserve_rd];
    assign w_ex_ok          = !r_busy[ex_rd];
    assign w_ex_elig        = ex_valid && w_ex_ok;
    assign w_ld_elig        = ld_done_valid && !w_fifo_empty;
    assign w_contend        = w_ld_elig && w_ex_elig;

    always_comb begin
        ld_done_ready = !w_fifo_empty && (!w_ex_elig || (r_rr == GrantLoad));
        ex_ready      = w_ex_ok && (!w_ld_elig || (r_rr == GrantExec));
    end

    assign w_res_fire  = ld_reserve_valid && ld_reserve_ready;
    assign w_done_fire = ld_done_valid && ld_done_ready;
    assign w_ex_fire   = ex_valid && ex_ready;

    always_comb begin
        w_rr_next = r_rr;
        if (w_contend) begin
            w_rr_next = grant_other(r_rr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr <= GrantLoad;
        end else begin
            r_rr <= w_rr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rf_rd      <= '0;
            r_rf_data    <= '0;
            r_rf_we      <= 1'b0;
            r_rf_from_ld <= 1'b0;
        end else if (w_done_fire) begin
            r_rf_rd      <= w_head;
            r_rf_data    <= ld_done_data;
            r_rf_we      <= (w_head != '0);
            r_rf_from_ld <= 1'b1;
        end else if (w_ex_fire) begin
            r_rf_rd      <= ex_rd;
            r_rf_data    <= ex_data;
            r_rf_we      <= (ex_rd != '0);
            r_rf_from_ld <= 1'b0;
        end else begin
            r_rf_we      <= 1'b0;
            r_rf_from_ld <= 1'b0;
        end
    end

    // Clear and set never hit the same register: a busy rd blocks reservation.
    always_comb begin
        w_busy_next = r_busy;
        if (r_rf_we && r_rf_from_ld) begin
            w_busy_next[r_rf_rd] = 1'b0;
        end
        if (w_res_fire && (ld_reserve_rd != '0)) begin
            w_busy_next[ld_reserve_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    always_comb begin
        w_haz_busy = ((query_rs1 != '0) && r_busy[query_rs1])
                  || ((query_rs2 != '0) && r_busy[query_rs2])
                  || ((query_rd  != '0) && r_busy[query_rd]);
        w_haz_inflight = r_rf_we
                      && (((query_rs1 != '0) && (r_rf_rd == query_rs1))
                       || ((query_rs2 != '0) && (r_rf_rd == query_rs2)));
        hazard = w_haz_busy || w_haz_inflight;
    end

    assign rf_rd           = r_rf_rd;
    assign rf_data         = r_rf_data;
    assign rf_write_enable = r_rf_we;

endmodule
